// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one byte per req/ack handshake,
// presents it downstream under valid/ready and stops for good on the halt word.
module instr_fetch #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter logic [7:0] HALT_CODE = 8'hFF
) (
  input  logic       ck,
  input  logic       rst_n,
  output logic       imem_req,
  output logic [7:0] imem_addr,
  input  logic       imem_ack,
  input  logic [7:0] imem_data,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr,
  output logic [2:0] op,
  output logic       last_bit,
  output logic [7:0] instr_pc,
  input  logic       pc_src,
  input  logic [7:0] jump_target,
  output logic       halted
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, HALT} state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] pc;
  logic       fetch_done;
  logic       accept;

  function automatic logic [7:0] next_pc(input logic [7:0] cur, input logic seq,
                                         input logic [7:0] target);
    // Sequential step wraps modulo 256 with no carry out.
    next_pc = seq ? cur + 8'd1 : target;
  endfunction

  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    fetch_done  = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          fetch_done = 1'b1;
          state_nxt  = (imem_data == HALT_CODE) ? HALT : HOLD;
        end
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          accept    = 1'b1;
          state_nxt = REQ;
        end
      end
      HALT: halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= 8'h00;
      instr_pc <= RESET_PC;
    end else begin
      state <= state_nxt;
      // The halt word is captured too so it stays visible on instr for debug.
      if (fetch_done) begin
        instr    <= imem_data;
        instr_pc <= pc;
      end
      if (accept) pc <= next_pc(pc, pc_src, jump_target);
    end
  end

  assign imem_addr = pc;
  assign op        = instr[7:5];
  assign last_bit  = instr[0];

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model plus PC model feed a scoreboard that is
// checked on every accepted instruction; a second instance covers RESET_PC wrap.
module tb_instr_fetch;
  localparam logic [7:0] HALT = 8'hFF;

  logic       ck = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req, instr_valid, last_bit, halted;
  logic [7:0] imem_addr, instr, instr_pc;
  logic [2:0] op;
  logic       imem_ack = 1'b0, instr_ready = 1'b0, pc_src = 1'b1;
  logic [7:0] imem_data = 8'h00, jump_target = 8'h00;

  logic       w_imem_req, w_instr_valid, w_last_bit, w_halted;
  logic [7:0] w_imem_addr, w_instr, w_instr_pc;
  logic [2:0] w_op;
  logic       w_imem_ack = 1'b0, w_instr_ready = 1'b0, w_pc_src = 1'b1;
  logic [7:0] w_imem_data = 8'h00, w_jump_target = 8'h00;

  int errors = 0, checks = 0, ncyc = 0, accepts = 0, wait_cnt = 0, ack_delay = 0;
  logic       junk_ack = 1'b0, halt_seen = 1'b0;
  logic [7:0] exp_pc = 8'h00;
  logic [7:0] mem [256];

  typedef struct packed {
    logic [7:0] instr;
    logic [2:0] op;
    logic       lb;
    logic [7:0] pc;
  } exp_t;
  exp_t       sbq[$];
  int         acc_cyc[$];
  logic [7:0] fetch_log[$];

  always #5 ck = ~ck;

  instr_fetch #(.RESET_PC(8'h00), .HALT_CODE(HALT)) dut (
    .ck(ck), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .op(op), .last_bit(last_bit),
    .instr_pc(instr_pc), .pc_src(pc_src), .jump_target(jump_target), .halted(halted)
  );

  instr_fetch #(.RESET_PC(8'hFF), .HALT_CODE(HALT)) dut_wrap (
    .ck(ck), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(w_imem_ack), .imem_data(w_imem_data), .instr_valid(w_instr_valid),
    .instr_ready(w_instr_ready), .instr(w_instr), .op(w_op), .last_bit(w_last_bit),
    .instr_pc(w_instr_pc), .pc_src(w_pc_src), .jump_target(w_jump_target),
    .halted(w_halted)
  );

  // Called at a falling edge: score any accept, drive memory, advance one cycle.
  task automatic cycle();
    exp_t       e;
    logic [7:0] d;
    if (instr_valid && instr_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_empty: accepted instr=%h pc=%h, expected no instruction", instr, instr_pc);
      end else begin
        e = sbq.pop_front();
        checks++;
        if ({instr, op, last_bit, instr_pc} !== e) begin
          errors++;
          $display("FAIL sb_instr: got instr=%h op=%0d lb=%b pc=%h, expected instr=%h op=%0d lb=%b pc=%h",
                   instr, op, last_bit, instr_pc, e.instr, e.op, e.lb, e.pc);
        end
      end
      exp_pc = pc_src ? exp_pc + 8'd1 : jump_target;
      accepts++;
      acc_cyc.push_back(ncyc);
    end
    if (imem_req) begin
      if (wait_cnt >= ack_delay) begin
        checks++;
        if (imem_addr !== exp_pc) begin
          errors++;
          $display("FAIL fetch_addr: got %h expected %h", imem_addr, exp_pc);
        end
        d = mem[imem_addr];
        imem_ack = 1'b1;
        imem_data = d;
        wait_cnt = 0;
        fetch_log.push_back(imem_addr);
        if (d != HALT) sbq.push_back('{d, d[7:5], d[0], exp_pc});
        else halt_seen = 1'b1;
      end else begin
        imem_ack = 1'b0;
        imem_data = 8'h00;
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
      imem_ack = junk_ack;
      imem_data = junk_ack ? 8'h99 : 8'h00;
    end
    @(negedge ck);
    ncyc++;
  endtask

  // Leaves the bench at the falling edge of the single IDLE cycle.
  task automatic do_reset();
    rst_n = 1'b0;
    imem_ack = 1'b0; imem_data = 8'h00; junk_ack = 1'b0; halt_seen = 1'b0;
    instr_ready = 1'b0; pc_src = 1'b1; jump_target = 8'h00;
    w_imem_ack = 1'b0; w_instr_ready = 1'b0; w_pc_src = 1'b1;
    sbq.delete(); acc_cyc.delete(); fetch_log.delete();
    exp_pc = 8'h00; accepts = 0; wait_cnt = 0;
    repeat (2) @(negedge ck);
    @(posedge ck);
    #1 rst_n = 1'b1;
    @(negedge ck);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge ck);
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got req/valid/halted=%b expected 000", {imem_req, instr_valid, halted});
    end
    checks++;
    if ({imem_addr, instr_pc, instr, op, last_bit} !== 28'h0) begin
      errors++; $display("FAIL reset_data: got addr=%h pc=%h instr=%h op=%0d lb=%b expected all zero",
                         imem_addr, instr_pc, instr, op, last_bit);
    end
    checks++;
    if ({w_imem_addr, w_instr_pc} !== 16'hFFFF) begin
      errors++; $display("FAIL reset_pc_param: got addr=%h pc=%h expected ff ff", w_imem_addr, w_instr_pc);
    end
    do_reset();
    checks++;
    if (imem_req !== 1'b0) begin
      errors++; $display("FAIL idle_cycle: got imem_req=%b expected 0", imem_req);
    end
    ack_delay = 100;
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected 1 00", imem_req, imem_addr);
    end
    cycle();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({imem_req, instr_valid, halted} !== 3'b000) begin
      errors++; $display("FAIL mid_fetch_reset: got req/valid/halted=%b expected 000", {imem_req, instr_valid, halted});
    end
    imem_ack = 1'b1;
    imem_data = 8'h55;
    @(posedge ck);
    #1 rst_n = 1'b1;
    @(negedge ck);
    @(negedge ck);
    imem_ack = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || instr !== 8'h00) begin
      errors++; $display("FAIL late_ack: got req=%b valid=%b instr=%h expected 1 0 00", imem_req, instr_valid, instr);
    end
    ack_delay = 0;
  endtask

  task automatic test_sequential();
    logic [7:0] a;
    do_reset();
    mem[0] = 8'h40; mem[1] = 8'h61; mem[2] = 8'hC3; mem[3] = 8'h00;
    ack_delay = 0; instr_ready = 1'b1; pc_src = 1'b1;
    for (int i = 0; i < 40 && accepts < 3; i++) cycle();
    instr_ready = 1'b0;
    checks++;
    if (accepts != 3) begin
      errors++; $display("FAIL seq_count: got %0d accepts expected 3", accepts);
    end
    for (int i = 0; i < 3; i++) begin
      a = (i < fetch_log.size()) ? fetch_log[i] : 8'hxx;
      checks++;
      if (a !== 8'(i)) begin
        errors++; $display("FAIL seq_addr%0d: got %h expected %h", i, a, 8'(i));
      end
    end
    for (int i = 1; i < acc_cyc.size(); i++) begin
      checks++;
      if (acc_cyc[i] - acc_cyc[i-1] != 2) begin
        errors++; $display("FAIL seq_rate: got %0d cycles between accepts expected 2", acc_cyc[i] - acc_cyc[i-1]);
      end
    end
  endtask

  task automatic test_backpressure();
    int req_cycles;
    do_reset();
    mem[0] = 8'hA5; mem[1] = 8'h22;
    ack_delay = 3; instr_ready = 1'b0; req_cycles = 0;
    cycle();
    for (int i = 0; i < 20 && !instr_valid; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
        errors++; $display("FAIL wait_addr: got req=%b addr=%h expected 1 00", imem_req, imem_addr);
      end
      req_cycles++;
      cycle();
    end
    checks++;
    if (instr_valid !== 1'b1 || req_cycles != 4) begin
      errors++; $display("FAIL ack_wait: got valid=%b after %0d req cycles expected 1 after 4", instr_valid, req_cycles);
    end
    junk_ack = 1'b1;
    repeat (4) begin
      cycle();
      checks++;
      if (instr_valid !== 1'b1 || imem_req !== 1'b0 || instr !== 8'hA5 || instr_pc !== 8'h00) begin
        errors++; $display("FAIL hold_stable: got valid=%b req=%b instr=%h pc=%h expected 1 0 a5 00",
                           instr_valid, imem_req, instr, instr_pc);
      end
    end
    junk_ack = 1'b0;
    instr_ready = 1'b1;
    cycle();
    instr_ready = 1'b0;
    checks++;
    if (accepts != 1) begin
      errors++; $display("FAIL accept_first_ready: got %0d accepts expected 1", accepts);
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      errors++; $display("FAIL post_accept_req: got req=%b addr=%h expected 1 01", imem_req, imem_addr);
    end
  endtask

  task automatic test_jump();
    logic jumped, done;
    do_reset();
    for (int i = 0; i < 6; i++) mem[i] = 8'h10 + 8'(i);
    mem[8'h20] = 8'h11;
    ack_delay = 0; instr_ready = 1'b1; jumped = 1'b0; done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (instr_valid && instr_pc == 8'h05) begin
        pc_src = 1'b0; jump_target = 8'h20; jumped = 1'b1;
      end else if (instr_valid) begin
        pc_src = 1'b1; jump_target = 8'($urandom);
      end else begin
        pc_src = 1'($urandom); jump_target = 8'($urandom);
      end
      cycle();
      if (jumped) begin
        done = 1'b1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 8'h20) begin
          errors++; $display("FAIL jump_addr: got req=%b addr=%h expected 1 20", imem_req, imem_addr);
        end
      end
    end
    checks++;
    if (!done) begin
      errors++; $display("FAIL jump_timeout: got no accept at pc 05 expected one");
    end
    pc_src = 1'b1;
    cycle();
    cycle();
    instr_ready = 1'b0;
  endtask

  task automatic test_halt();
    do_reset();
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = HALT;
    ack_delay = 0; instr_ready = 1'b1; pc_src = 1'b1;
    for (int i = 0; i < 40 && !halt_seen; i++) begin
      checks++;
      if (instr_valid && instr === HALT) begin
        errors++; $display("FAIL halt_presented: got valid=1 instr=%h expected halt word never valid", instr);
      end
      cycle();
    end
    checks++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || instr !== HALT || instr_pc !== 8'h03) begin
      errors++; $display("FAIL halt_entry: got halted=%b valid=%b instr=%h pc=%h expected 1 0 ff 03",
                         halted, instr_valid, instr, instr_pc);
    end
    junk_ack = 1'b1;
    repeat (20) begin
      cycle();
      checks++;
      if (imem_req !== 1'b0 || halted !== 1'b1 || instr_valid !== 1'b0) begin
        errors++; $display("FAIL halt_hold: got req=%b halted=%b valid=%b expected 0 1 0", imem_req, halted, instr_valid);
      end
    end
    junk_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b0) begin
      errors++; $display("FAIL halt_reset: got halted=%b req=%b expected 0 0", halted, imem_req);
    end
    do_reset();
    cycle();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || halted !== 1'b0) begin
      errors++; $display("FAIL halt_restart: got req=%b addr=%h halted=%b expected 1 00 0", imem_req, imem_addr, halted);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cycle();
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 8'hFF) begin
      errors++; $display("FAIL wrap_first_req: got req=%b addr=%h expected 1 ff", w_imem_req, w_imem_addr);
    end
    w_imem_ack = 1'b1;
    w_imem_data = 8'h41;
    cycle();
    w_imem_ack = 1'b0;
    checks++;
    if (w_instr_valid !== 1'b1 || w_instr_pc !== 8'hFF || w_instr !== 8'h41 ||
        w_op !== 3'd2 || w_last_bit !== 1'b1 || w_halted !== 1'b0) begin
      errors++; $display("FAIL wrap_instr: got valid=%b pc=%h instr=%h op=%0d lb=%b halted=%b expected 1 ff 41 2 1 0",
                         w_instr_valid, w_instr_pc, w_instr, w_op, w_last_bit, w_halted);
    end
    w_instr_ready = 1'b1;
    w_pc_src = 1'b1;
    w_jump_target = 8'h77;
    cycle();
    w_instr_ready = 1'b0;
    checks++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== 8'h00) begin
      errors++; $display("FAIL wrap_addr: got req=%b addr=%h expected 1 00", w_imem_req, w_imem_addr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump();
    test_halt();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the 8-bit datapath, directly upstream of the opcode Control unit. It holds the program counter and requests one 8-bit instruction per fetch from instruction memory over a req/ack handshake. It presents the instruction with its decoded `op[2:0]` and `last_bit` fields under a valid/ready handshake. On each accepted instruction it advances the PC sequentially or loads a jump target supplied by the downstream stage, and it stops permanently on the halt encoding 8'hFF.

## Interface
- `RESET_PC`, default 8'h00: PC value loaded on reset.
- `HALT_CODE`, default 8'hFF: instruction encoding that halts fetch.
- `ck`  in  1: clock, rising edge.
- `rst_n`  in  1: reset. One clock; reset is asynchronous and active-low.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_addr`  out  8: fetch address. Equals current PC.
- `imem_ack`  in  1: memory has data. Sampled only while `imem_req`=1.
- `imem_data`  in  8: instruction word. Valid in the cycle `imem_ack`=1.
- `instr_valid`  out  1: `instr`/`op`/`last_bit`/`instr_pc` are valid.
- `instr_ready`  in  1: downstream accepts the instruction.
- `instr`  out  8: registered instruction word.
- `op`  out  3: `instr[7:5]`.
- `last_bit`  out  1: `instr[0]`.
- `instr_pc`  out  8: address the presented instruction was fetched from.
- `pc_src`  in  1: sampled at accept. 1 selects PC+1; 0 loads `jump_target`.
- `jump_target`  in  8: next PC when `pc_src`=0. Sampled at accept.
- `halted`  out  1: halt instruction fetched; fetch stopped.

## Operation
- State machine states and transitions:
  - IDLE → REQ unconditionally. IDLE is entered only from reset.
  - REQ: `imem_req`=1, `imem_addr`=PC.
    - If `imem_ack`=1 and `imem_data`≠HALT_CODE, capture `imem_data` into `instr`, capture PC into `instr_pc`, and go to HOLD.
    - If `imem_ack`=1 and `imem_data`==HALT_CODE, capture the word and go to HALT.
    - If `imem_ack`=0, stay in REQ.
  - HOLD: `instr_valid`=1.
    - If `instr_ready`=1 (accept), update PC and go to REQ.
    - Otherwise stay in HOLD with all outputs held stable.
  - HALT: `halted`=1, `imem_req`=0, `instr_valid`=0. Only reset leaves HALT.
- PC update at accept: PC ← `pc_src` ? PC+1 : `jump_target`.
  - 8-bit modulo arithmetic: 8'hFF+1 = 8'h00, with no flag.
- `op` and `last_bit` are combinational slices of the `instr` register and are stable while `instr_valid`=1.
- `imem_addr` and `imem_req` are registered or state-derived. They must not change while waiting for ack.
- `imem_ack` outside REQ is ignored, with no state change.
- The HALT_CODE word is never presented with `instr_valid`. `instr` holds HALT_CODE after the halt for debug.

## Timing
- Reset (asynchronous assert, any state):
  - PC=RESET_PC, `instr_pc`=RESET_PC, `instr`=8'h00, `op`=0, `last_bit`=0.
  - `imem_req`=0, `instr_valid`=0, `halted`=0, state=IDLE.
  - Deassertion is followed by one IDLE cycle, then `imem_req`=1.
- Reset mid-fetch: the outstanding request is dropped. A late `imem_ack` after reset is ignored because the FSM is not in REQ until one cycle after IDLE.
- Fetch latency: `imem_ack` at edge N gives `instr_valid`=1 after edge N. Zero-wait memory (ack high in the first REQ cycle) gives 2 cycles per instruction: REQ then HOLD.
- Accept at edge M gives the new PC on `imem_addr` with `imem_req`=1 after edge M. There is no bubble beyond the REQ cycle.
- `pc_src` and `jump_target` are sampled only at the accept edge. Values in other cycles have no effect.
- Backpressure: `instr_ready`=0 holds `instr_valid`=1 indefinitely, with no new request issued.
- Simultaneous reset and accept: reset wins.

## Test plan
- Reset with `rst_n`=0, then release:
  - During reset: all outputs at their reset values.
  - First cycle after release: `imem_req`=0.
  - Second cycle: `imem_req`=1, `imem_addr`=8'h00.
- Zero-wait ack, ready tied 1, `pc_src`=1, memory returning 8'h40, 8'h61, 8'hC3:
  - `imem_addr` sequence is 00, 01, 02, with `op` = 2, 3, 6.
  - `last_bit` = 0, 1, 1; one instruction every 2 cycles.
- 3-cycle ack delay plus `instr_ready` low for 4 cycles:
  - `imem_addr` is stable throughout the wait.
  - `instr`/`instr_pc` are held and no second request is issued.
  - Accept occurs on the first ready-high cycle.
- Jump: accept at PC 8'h05 with `pc_src`=0, `jump_target`=8'h20 → next `imem_addr`=8'h20.
- Wrap: `RESET_PC`=8'hFF, sequential accept → next `imem_addr`=8'h00, `instr_pc`=8'hFF for the first instruction.
- Halt: memory returns 8'hFF at PC 8'h03:
  - `halted`=1 from the next cycle, with `instr_valid` never asserted for that word.
  - `imem_req` stays 0 for 20 cycles.
  - Asserting `rst_n`=0 clears `halted` and restarts the fetch at 8'h00.
